miter_seq_cmp_prop: RTL and testbench



---
 rtl/miter_pkg.sv | 32 +++
 rtl/miter_delay_line.sv | 41 ++++
 rtl/miter_seq_cmp_prop.sv | 181 ++++++++++++++++++
 tb/tb_miter_seq_cmp_prop.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/miter_pkg.sv
// Shared state encoding, property-kind names and the X-tolerant channel
// compare used by the sequential gold/gate miter comparator.
package miter_pkg;

  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    CHECK  = 2'd1,
    FAIL   = 2'd2
  } miter_state_e;

  localparam string PROP_ASSERT = "assert";
  localparam string PROP_ASSUME = "assume";
  localparam string PROP_COVER  = "cover";

  localparam int CHAN_MAX_W = 64;

  function automatic int chan_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Unknown gold bits are don't-cares; callers zero-pad both operands alike.
  function automatic logic chan_match(input logic [CHAN_MAX_W-1:0] gold,
                                      input logic [CHAN_MAX_W-1:0] gate);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < CHAN_MAX_W; i++) begin
      if (!((gold[i] === 1'bx) || (gold[i] === gate[i]))) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/miter_delay_line.sv
// Valid-enabled shift register that aligns gold with a pipelined gate.
// STAGES=0 is a pure wire.
module miter_delay_line #(
  parameter int W      = 1,
  parameter int STAGES = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  if (STAGES == 0) begin : g_bypass
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst_n, clr_i, en_i};
    assign q_o = d_i;
  end else begin : g_pipe
`ifdef SYNTHESIS
    localparam logic [W-1:0] FLUSH = '0;
`else
    localparam logic [W-1:0] FLUSH = 'x;
`endif
    logic [W-1:0] stage_q [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s < STAGES; s++) stage_q[s] <= FLUSH;
      end else if (clr_i) begin
        for (int s = 0; s < STAGES; s++) stage_q[s] <= FLUSH;
      end else if (en_i) begin
        stage_q[0] <= d_i;
        for (int s = 1; s < STAGES; s++) stage_q[s] <= stage_q[s-1];
      end
    end

    assign q_o = stage_q[STAGES-1];
  end

endmodule

// File: rtl/miter_seq_cmp_prop.sv
// Sequential multi-lane gold/gate miter compare with sticky failure record.
// WARMUP: gold delay filling | CHECK: comparing, no miss yet | FAIL: miss seen
module miter_seq_cmp_prop
  import miter_pkg::*;
#(
  parameter int    WIDTH        = 1,
  parameter int    CHANNELS     = 1,
  parameter int    GOLD_LAT     = 0,
  parameter int    CNT_W        = 8,
  parameter int    TS_W         = 16,
  parameter string TYPE         = PROP_ASSERT,
  parameter bit    STOP_ON_FAIL = 1'b1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                clr_i,
  input  logic                                valid_i,
  input  logic [CHANNELS*WIDTH-1:0]           in_gold_i,
  input  logic [CHANNELS*WIDTH-1:0]           in_gate_i,
  output logic                                okay_o,
  output logic                                fail_o,
  output logic [CNT_W-1:0]                    mis_cnt_o,
  output logic [chan_idx_w(CHANNELS)-1:0]     first_chan_o,
  output logic [TS_W-1:0]                     first_ts_o,
  output logic [1:0]                          state_o
);

  localparam int               CW        = chan_idx_w(CHANNELS);
  localparam int               DW        = CHANNELS * WIDTH;
  localparam logic [3:0]       WARM_LOAD = 4'(GOLD_LAT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [TS_W-1:0]  TS_MAX    = '1;

  miter_state_e        state_q, state_d;
  logic                okay_q, okay_d;
  logic                fail_q, fail_d;
  logic [CNT_W-1:0]    mis_q, mis_d;
  logic [CW-1:0]       fchan_q, fchan_d;
  logic [TS_W-1:0]     fts_q, fts_d;
  logic [TS_W-1:0]     ts_q, ts_d;
  logic [3:0]          warm_q, warm_d;

  logic [DW-1:0]           gold_dly;
  logic                    shift_en;
  logic [CHANNELS-1:0]     chan_ok;
  logic                    sample_ok;
  logic [CW-1:0]           low_bad;
  logic [CHAN_MAX_W-1:0]   g_ext, t_ext;

  // A cleared sample must not enter the delay line either.
  assign shift_en = valid_i && !clr_i;

  miter_delay_line #(
    .W      (DW),
    .STAGES (GOLD_LAT)
  ) u_gold_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (clr_i),
    .en_i  (shift_en),
    .d_i   (in_gold_i),
    .q_o   (gold_dly)
  );

  always_comb begin
    chan_ok = '1;
    low_bad = '0;
    g_ext   = '0;
    t_ext   = '0;
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      g_ext = '0;
      t_ext = '0;
      g_ext[WIDTH-1:0] = gold_dly[c*WIDTH +: WIDTH];
      t_ext[WIDTH-1:0] = in_gate_i[c*WIDTH +: WIDTH];
      chan_ok[c] = chan_match(g_ext, t_ext);
      if (!chan_ok[c]) low_bad = CW'(c);
    end
  end

  assign sample_ok = &chan_ok;

  always_comb begin
    state_d = state_q;
    okay_d  = okay_q;
    fail_d  = fail_q;
    mis_d   = mis_q;
    fchan_d = fchan_q;
    fts_d   = fts_q;
    ts_d    = ts_q;
    warm_d  = warm_q;
    if (clr_i) begin
      state_d = WARMUP;
      okay_d  = 1'b1;
      fail_d  = 1'b0;
      mis_d   = '0;
      fchan_d = '0;
      fts_d   = '0;
      ts_d    = '0;
      warm_d  = WARM_LOAD;
    end else begin
      unique case (state_q)
        WARMUP: begin
          if (warm_q == 4'd0) begin
            state_d = CHECK;
          end else if (valid_i) begin
            warm_d = warm_q - 4'd1;
            if (warm_q == 4'd1) state_d = CHECK;
          end
        end
        CHECK: begin
          if (valid_i) begin
            okay_d = sample_ok;
            if (ts_q != TS_MAX) ts_d = ts_q + 1'b1;
            if (!sample_ok) begin
              fail_d  = 1'b1;
              if (mis_q != CNT_MAX) mis_d = mis_q + 1'b1;
              fchan_d = low_bad;
              fts_d   = ts_q;
              state_d = FAIL;
            end
          end
        end
        FAIL: begin
          if (valid_i) begin
            okay_d = sample_ok;
            if (!STOP_ON_FAIL) begin
              if (ts_q != TS_MAX) ts_d = ts_q + 1'b1;
              if (!sample_ok && (mis_q != CNT_MAX)) mis_d = mis_q + 1'b1;
            end
          end
        end
        default: state_d = WARMUP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WARMUP;
      okay_q  <= 1'b1;
      fail_q  <= 1'b0;
      mis_q   <= '0;
      fchan_q <= '0;
      fts_q   <= '0;
      ts_q    <= '0;
      warm_q  <= WARM_LOAD;
    end else begin
      state_q <= state_d;
      okay_q  <= okay_d;
      fail_q  <= fail_d;
      mis_q   <= mis_d;
      fchan_q <= fchan_d;
      fts_q   <= fts_d;
      ts_q    <= ts_d;
      warm_q  <= warm_d;
    end
  end

  assign okay_o       = okay_q;
  assign fail_o       = fail_q;
  assign mis_cnt_o    = mis_q;
  assign first_chan_o = fchan_q;
  assign first_ts_o   = fts_q;
  assign state_o      = state_q;

  // Property on the registered result; silent in reset and while warming up.
  if (TYPE == PROP_ASSUME) begin : g_assume
    always @(posedge clk) begin
      if (rst_n && (state_q != WARMUP)) assume (okay_q);
    end
  end else if (TYPE == PROP_COVER) begin : g_cover
    always @(posedge clk) begin
      if (rst_n && (state_q != WARMUP)) cover (okay_q);
    end
  end else begin : g_assert
    always @(posedge clk) begin
      if (rst_n && (state_q != WARMUP)) assert (okay_q);
    end
  end

endmodule

// File: tb/tb_miter_seq_cmp_prop.sv
// Randomized bench for miter_seq_cmp_prop: two configurations share one
// stimulus stream and are checked against a queue-based reference model.
module tb_miter_seq_cmp_prop;
  localparam int W   = 8;
  localparam int CH  = 2;
  localparam int LAT = 2;
  localparam int DW  = W * CH;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr   = 1'b0;
  logic          valid = 1'b0;
  logic [DW-1:0] gold  = '0;
  logic [DW-1:0] gate  = '0;

  logic        okay_a, fail_a, fchan_a;
  logic [7:0]  mis_a;
  logic [15:0] fts_a;
  logic [1:0]  st_a;
  logic        okay_b, fail_b, fchan_b;
  logic [1:0]  mis_b;
  logic [3:0]  fts_b;
  logic [1:0]  st_b;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  miter_seq_cmp_prop #(
    .WIDTH(W), .CHANNELS(CH), .GOLD_LAT(LAT), .CNT_W(8), .TS_W(16),
    .TYPE("cover"), .STOP_ON_FAIL(1'b1)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .clr_i(clr), .valid_i(valid),
    .in_gold_i(gold), .in_gate_i(gate),
    .okay_o(okay_a), .fail_o(fail_a), .mis_cnt_o(mis_a),
    .first_chan_o(fchan_a), .first_ts_o(fts_a), .state_o(st_a)
  );

  miter_seq_cmp_prop #(
    .WIDTH(W), .CHANNELS(CH), .GOLD_LAT(LAT), .CNT_W(2), .TS_W(4),
    .TYPE("cover"), .STOP_ON_FAIL(1'b0)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .clr_i(clr), .valid_i(valid),
    .in_gold_i(gold), .in_gate_i(gate),
    .okay_o(okay_b), .fail_o(fail_b), .mis_cnt_o(mis_b),
    .first_chan_o(fchan_b), .first_ts_o(fts_b), .state_o(st_b)
  );

  // Reference model: gold samples since the last clear, plus event counts.
  logic [DW-1:0] pipe[$];
  logic [DW-1:0] hist[$];
  logic          m_okay;
  int            m_nfail, m_fchan, m_fts, m_ncheck;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    pipe.delete();
    m_okay   = 1'b1;
    m_nfail  = 0;
    m_fchan  = 0;
    m_fts    = 0;
    m_ncheck = 0;
  endtask

  task automatic model_update(input logic c, input logic v, input logic [DW-1:0] g,
                              input logic [DW-1:0] t);
    logic [DW-1:0] gd;
    int low;
    logic bad;
    if (c) begin
      model_clear();
    end else if (v) begin
      pipe.push_back(g);
      if (pipe.size() > LAT) begin
        gd  = pipe.pop_front();
        low = -1;
        for (int ch = 0; ch < CH; ch++) begin
          bad = 1'b0;
          for (int b = 0; b < W; b++) begin
            if (!((gd[ch*W+b] === 1'bx) || (gd[ch*W+b] === t[ch*W+b]))) bad = 1'b1;
          end
          if (bad && (low < 0)) low = ch;
        end
        m_okay = (low < 0);
        if (low >= 0) begin
          if (m_nfail == 0) begin
            m_fchan = low;
            m_fts   = m_ncheck;
          end
          m_nfail++;
        end
        m_ncheck++;
      end
    end
  endtask

  task automatic check_dut(input string p, input logic ok, input logic f, input logic [31:0] mis,
                           input logic [31:0] fch, input logic [31:0] fts, input logic [31:0] st,
                           input int cmax, input int tmax, input bit stop);
    int exp_mis, exp_st;
    exp_mis = stop ? int'(m_nfail > 0) : ((m_nfail > cmax) ? cmax : m_nfail);
    exp_st  = (m_nfail > 0) ? 2 : ((pipe.size() >= LAT) ? 1 : 0);
    check_val({p, ".okay"}, 32'(ok), 32'(m_okay));
    check_val({p, ".fail"}, 32'(f), 32'(m_nfail > 0));
    check_val({p, ".mis_cnt"}, mis, exp_mis);
    check_val({p, ".first_chan"}, fch, m_fchan);
    check_val({p, ".first_ts"}, fts, (m_fts > tmax) ? tmax : m_fts);
    check_val({p, ".state"}, st, exp_st);
  endtask

  task automatic check_all();
    check_dut("A", okay_a, fail_a, 32'(mis_a), 32'(fchan_a), 32'(fts_a), 32'(st_a), 255, 65535, 1'b1);
    check_dut("B", okay_b, fail_b, 32'(mis_b), 32'(fchan_b), 32'(fts_b), 32'(st_b), 3, 15, 1'b0);
  endtask

  task automatic cyc(input logic c, input logic v, input logic [DW-1:0] g, input logic [DW-1:0] t);
    clr   = c;
    valid = v;
    gold  = g;
    gate  = t;
    @(posedge clk);
    model_update(c, v, g, t);
    @(negedge clk);
    check_all();
  endtask

  // Gate reproduces gold from two valid samples earlier, optionally corrupted.
  task automatic send(input logic [DW-1:0] mask, input logic [DW-1:0] g);
    logic [DW-1:0] t;
    t = (hist.size() >= 2) ? hist[hist.size()-2] : '0;
    t = t ^ mask;
    hist.push_back(g);
    if (hist.size() > 8) void'(hist.pop_front());
    cyc(1'b0, 1'b1, g, t);
  endtask

  // Directed gold always has bits 0 and 11 set so a flip is a real mismatch.
  function automatic logic [DW-1:0] dg();
    return DW'($urandom) | 16'h0801;
  endfunction

  initial begin
    logic [DW-1:0] g, t;
    int r;
    model_clear();
    repeat (3) @(negedge clk);
    check_val("in_reset.okay", 32'(okay_a), 32'd1);
    rst_n = 1'b1;
    check_all();

    for (int i = 0; i < 20; i++) begin
      send('0, dg());
      if (i == 0) check_val("warm.after1.state", 32'(st_a), 32'd0);
      if (i == 1) check_val("warm.after2.state", 32'(st_a), 32'd1);
    end
    check_val("clean.okay", 32'(okay_a), 32'd1);
    check_val("clean.fail", 32'(fail_a), 32'd0);
    check_val("clean.mis", 32'(mis_a), 32'd0);

    cyc(1'b1, 1'b0, '0, '0);
    for (int i = 0; i < 10; i++) begin
      send((i == 7) ? 16'h0800 : 16'h0000, dg());
      if (i == 7) begin
        check_val("flip7.okay", 32'(okay_a), 32'd0);
        check_val("flip7.fail", 32'(fail_a), 32'd1);
        check_val("flip7.mis", 32'(mis_a), 32'd1);
        check_val("flip7.first_chan", 32'(fchan_a), 32'd1);
        check_val("flip7.first_ts", 32'(fts_a), 32'd5);
        check_val("flip7.state", 32'(st_a), 32'd2);
      end
    end

    for (int i = 0; i < 5; i++) send(16'h0001, dg());
    check_val("sat.B.mis", 32'(mis_b), 32'd3);
    check_val("sat.B.first_chan", 32'(fchan_b), 32'd1);
    check_val("sat.B.first_ts", 32'(fts_b), 32'd5);
    check_val("stop.A.mis", 32'(mis_a), 32'd1);

    g = dg();
    cyc(1'b1, 1'b1, g, ~g);
    check_val("clr.A.okay", 32'(okay_a), 32'd1);
    check_val("clr.A.fail", 32'(fail_a), 32'd0);
    check_val("clr.A.mis", 32'(mis_a), 32'd0);
    check_val("clr.B.mis", 32'(mis_b), 32'd0);
    check_val("clr.A.first_ts", 32'(fts_a), 32'd0);
    check_val("clr.A.state", 32'(st_a), 32'd0);

    for (int i = 0; i < 12; i++) begin
      send('0, dg());
      repeat ($urandom_range(0, 2)) cyc(1'b0, 1'b0, DW'($urandom), DW'($urandom));
    end
    check_val("gaps.fail", 32'(fail_a), 32'd0);
    check_val("gaps.state", 32'(st_a), 32'd1);

    for (int i = 0; i < 10; i++) begin
      g = dg();
      if (i < 8) g[2] = 1'bx;
      t = hist[hist.size()-2];
      if (hist[hist.size()-2][2] === 1'bx) t[2] = 1'($urandom_range(0, 1));
      hist.push_back(g);
      if (hist.size() > 8) void'(hist.pop_front());
      cyc(1'b0, 1'b1, g, t);
    end
    check_val("xgold.okay", 32'(okay_a), 32'd1);
    check_val("xgold.fail", 32'(fail_a), 32'd0);

    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        cyc(1'b1, 1'($urandom_range(0, 1)), DW'($urandom), DW'($urandom));
      end else if (r < 30) begin
        cyc(1'b0, 1'b0, DW'($urandom), DW'($urandom));
      end else begin
        send(($urandom_range(0, 24) == 0) ? (DW'(1) << $urandom_range(0, DW-1)) : '0,
             DW'($urandom));
      end
    end

    cyc(1'b1, 1'b0, '0, '0);
    send('0, dg());
    send('0, dg());
    send(16'h0800, dg());
    check_val("prerst.state", 32'(st_a), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    check_all();
    check_val("async.fail", 32'(fail_a), 32'd0);
    check_val("async.state", 32'(st_b), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) send('0, dg());
    check_val("rewarm.state", 32'(st_a), 32'd1);
    check_val("rewarm.okay", 32'(okay_a), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
